// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter for the single-bit x/z sequence-detector link.
// A pattern word and length are captured on a load handshake. The pattern is then
// shifted out on x_o, most significant valid bit first, one bit per clock.
// Optional continuous looping is compiled in when SEQGEN_LOOP_EN is defined.
module seq_pattern_gen #(
  parameter int unsigned PATTERN_W = 13,
  parameter int unsigned LEN_W     = $clog2(PATTERN_W + 1),
  parameter logic        IDLE_BIT  = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [PATTERN_W-1:0] pattern_i,
  input  logic [LEN_W-1:0]     len_i,
  input  logic                 loop_mode_i,
  input  logic                 stop_i,
  output logic                 x_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [LEN_W-1:0]     bits_left_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [PATTERN_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     bits_left_q, bits_left_d;
  logic                 x_q, x_d;

  logic [LEN_W-1:0]     len_c;
  logic [PATTERN_W-1:0] first_sh, next_sh, wrap_sh;
  logic                 wrap_en;

`ifdef SEQGEN_LOOP_EN
  logic loop_q, loop_d;
  logic stop_q, stop_d;

  // Wrap to the first bit only while looping and no stop has been seen this lap.
  always_comb begin
    wrap_en = loop_q && !stop_q && !stop_i;
  end
`else
  // Loop controls have no function in this build.
  logic unused_loop_inputs;
  assign unused_loop_inputs = loop_mode_i ^ stop_i;

  // Single-shot only.
  always_comb begin
    wrap_en = 1'b0;
  end
`endif

  // Clamp the requested length and pre-select the bits needed for the next x.
  always_comb begin
    len_c    = (len_i > LEN_W'(PATTERN_W)) ? LEN_W'(PATTERN_W) : len_i;
    first_sh = pattern_i >> (len_c - LEN_W'(1));
    // Current bit sits at index bits_left-1, so the following one is bits_left-2.
    next_sh  = pat_q >> (bits_left_q - LEN_W'(2));
    wrap_sh  = pat_q >> (len_q - LEN_W'(1));
  end

  // Next-state logic for the shift FSM and its datapath.
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    len_d       = len_q;
    bits_left_d = bits_left_q;
    x_d         = IDLE_BIT;
`ifdef SEQGEN_LOOP_EN
    loop_d      = loop_q;
    stop_d      = stop_q;
`endif
    case (state_q)
      StShift: begin
`ifdef SEQGEN_LOOP_EN
        if (stop_i && loop_q) stop_d = 1'b1;
`endif
        if (bits_left_q == LEN_W'(1)) begin
          if (wrap_en) begin
            bits_left_d = len_q;
            x_d         = wrap_sh[0];
          end else begin
            state_d     = StDone;
            bits_left_d = '0;
`ifdef SEQGEN_LOOP_EN
            loop_d      = 1'b0;
            stop_d      = 1'b0;
`endif
          end
        end else begin
          bits_left_d = bits_left_q - LEN_W'(1);
          x_d         = next_sh[0];
        end
      end
      default: begin
        // Idle and Done both accept a new load.
        state_d     = StIdle;
        bits_left_d = '0;
        if (load_i) begin
          pat_d       = pattern_i;
          len_d       = len_c;
          bits_left_d = len_c;
`ifdef SEQGEN_LOOP_EN
          loop_d      = loop_mode_i && (len_c != '0);
          stop_d      = 1'b0;
`endif
          if (len_c == '0) begin
            state_d = StDone;
          end else begin
            state_d = StShift;
            x_d     = first_sh[0];
          end
        end
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      pat_q       <= '0;
      len_q       <= '0;
      bits_left_q <= '0;
      x_q         <= IDLE_BIT;
`ifdef SEQGEN_LOOP_EN
      loop_q      <= 1'b0;
      stop_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      bits_left_q <= bits_left_d;
      x_q         <= x_d;
`ifdef SEQGEN_LOOP_EN
      loop_q      <= loop_d;
      stop_q      <= stop_d;
`endif
    end
  end

  // Status outputs decode straight from the state register.
  always_comb begin
    x_o         = x_q;
    bits_left_o = bits_left_q;
    busy_o      = (state_q == StShift);
    ready_o     = (state_q != StShift);
    done_o      = (state_q == StDone);
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen with hand-computed expected bit streams.
module tb_seq_pattern_gen;

  localparam int unsigned PW = 13;
  localparam int unsigned LW = 4;

  logic          clk = 1'b0;
  logic          rst, load, loop_mode, stop;
  logic [PW-1:0] pattern;
  logic [LW-1:0] len;
  logic          x, ready, busy, done;
  logic [LW-1:0] bits_left;

  int n_vec = 0;
  int n_err = 0;

  bit exp1 [13];
  bit exp2a [4];
  bit exp2b [4];
  bit exp3 [8];
  bit exp6 [6];
  int bl6 [6];

  seq_pattern_gen dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (load),
    .pattern_i  (pattern),
    .len_i      (len),
    .loop_mode_i(loop_mode),
    .stop_i     (stop),
    .x_o        (x),
    .ready_o    (ready),
    .busy_o     (busy),
    .done_o     (done),
    .bits_left_o(bits_left)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit ex, input bit eb, input bit ed,
                         input int ebl);
    chk({tag, ".x"}, {31'd0, x}, {31'd0, ex});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
    chk({tag, ".ready"}, {31'd0, ready}, {31'd0, !eb});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, ed});
    chk({tag, ".bits_left"}, {28'd0, bits_left}, ebl);
  endtask

  initial begin
    exp1  = '{0, 0, 1, 1, 0, 1, 1, 0, 1, 1, 1, 0, 1};
    exp2a = '{1, 0, 1, 0};
    exp2b = '{0, 1, 1, 0};
    exp3  = '{1, 1, 0, 1, 0, 0, 1, 0};
    exp6  = '{1, 1, 0, 1, 1, 0};
    bl6   = '{3, 2, 1, 3, 2, 1};

    rst = 1'b1; load = 1'b0; loop_mode = 1'b0; stop = 1'b0; pattern = '0; len = '0;
    step();
    step();
    chk_all("reset", 1'b0, 1'b0, 1'b0, 0);
    rst = 1'b0;
    step();

    // Full-width pattern; inputs scrambled after the load.
    load = 1'b1; pattern = 13'b0011011011101; len = 4'd13;
    step();
    load = 1'b0; pattern = '1; len = 4'd3;
    for (int i = 0; i < 13; i++) begin
      chk_all($sformatf("t1.bit%0d", i), exp1[i], 1'b1, 1'b0, 13 - i);
      step();
    end
    chk_all("t1.done", 1'b0, 1'b0, 1'b1, 0);
    step();
    chk_all("t1.idle", 1'b0, 1'b0, 1'b0, 0);

    // Back-to-back bursts with a reload in the done cycle.
    load = 1'b1; pattern = 13'b0000000001010; len = 4'd4;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_all($sformatf("t2a.bit%0d", i), exp2a[i], 1'b1, 1'b0, 4 - i);
      step();
    end
    chk_all("t2.gap", 1'b0, 1'b0, 1'b1, 0);
    load = 1'b1; pattern = 13'b0000000000110; len = 4'd4;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_all($sformatf("t2b.bit%0d", i), exp2b[i], 1'b1, 1'b0, 4 - i);
      step();
    end
    chk_all("t2b.done", 1'b0, 1'b0, 1'b1, 0);
    step();

    // Load during shift is ignored; upper pattern bits beyond len are unused.
    load = 1'b1; pattern = 13'b1111111010010; len = 4'd8;
    step();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        load = 1'b1; pattern = '0; len = 4'd2;
      end
      chk_all($sformatf("t3.bit%0d", i), exp3[i], 1'b1, 1'b0, 8 - i);
      step();
      load = 1'b0;
    end
    chk_all("t3.done", 1'b0, 1'b0, 1'b1, 0);
    step();

    // Zero length goes straight to done.
    load = 1'b1; pattern = '1; len = 4'd0;
    step();
    load = 1'b0;
    chk_all("t4.done", 1'b0, 1'b0, 1'b1, 0);
    step();
    chk_all("t4.idle", 1'b0, 1'b0, 1'b0, 0);

    // Oversized length clamps to the pattern width.
    load = 1'b1; pattern = 13'b1000000000001; len = 4'd15;
    step();
    load = 1'b0;
    chk_all("clamp.first", 1'b1, 1'b1, 1'b0, 13);
    for (int i = 0; i < 11; i++) step();
    chk_all("clamp.mid", 1'b0, 1'b1, 1'b0, 2);
    step();
    chk_all("clamp.last", 1'b1, 1'b1, 1'b0, 1);
    step();
    chk_all("clamp.done", 1'b0, 1'b0, 1'b1, 0);
    step();

    // Reset mid-burst aborts without a done pulse.
    load = 1'b1; pattern = '1; len = 4'd13;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk_all("t5.pre", 1'b1, 1'b1, 1'b0, 9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all("t5.reset", 1'b0, 1'b0, 1'b0, 0);
    step();
    chk_all("t5.after", 1'b0, 1'b0, 1'b0, 0);

`ifdef SEQGEN_LOOP_EN
    // Looping pattern ended by a stop pulse in the second lap.
    load = 1'b1; pattern = 13'b0000000000110; len = 4'd3; loop_mode = 1'b1;
    step();
    load = 1'b0; loop_mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) stop = 1'b1;
      chk_all($sformatf("t6.bit%0d", i), exp6[i], 1'b1, 1'b0, bl6[i]);
      step();
      stop = 1'b0;
    end
    chk_all("t6.done", 1'b0, 1'b0, 1'b1, 0);
    step();
    chk_all("t6.idle", 1'b0, 1'b0, 1'b0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
